// File: rtl/gene_pkg.sv
// Shared definitions for the gene alignment datapath: base encoding, default
// array geometry and the tile controller state type.
package gene_pkg;

    localparam int DEF_PE_NUM  = 64;
    localparam int DEF_LEN_W   = 10;
    localparam int DEF_SCORE_W = 10;
    localparam int DEF_DRAIN   = 66;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_B,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_CAPTURE,
        ST_DONE
    } ctrl_state_e;

endpackage

// File: rtl/b_tile_loader.sv
// Fetches one PE_NUM-base segment of gene B from memory (1-cycle read latency)
// into the array's B register; runs PE_NUM+1 cycles after a start pulse.
module b_tile_loader
    import gene_pkg::*;
#(
    parameter int PE_NUM = DEF_PE_NUM,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    tile_base,
    output logic [LEN_W-1:0]    b_addr,
    input  logic [1:0]          b_data,
    output logic                done,
    output logic [2*PE_NUM-1:0] tile
);

    localparam int IDX_W = $clog2(PE_NUM + 2);

    logic             busy_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [LEN_W-1:0] addr_reg;

    // idx_reg is the LOAD_B cycle number; the address stops at the last base
    // while the final read's data is being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
            idx_reg  <= '0;
            addr_reg <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            idx_reg  <= '0;
            addr_reg <= tile_base;
        end else if (busy_reg) begin
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg < IDX_W'(PE_NUM - 1)) begin
                addr_reg <= addr_reg + 1'b1;
            end
            if (idx_reg == IDX_W'(PE_NUM)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign b_addr = addr_reg;
    assign done   = busy_reg && (idx_reg == IDX_W'(PE_NUM));

    genvar gi;
    generate
        for (gi = 0; gi < PE_NUM; gi++) begin : g_slot
            logic [1:0] slot_reg;

            // Data addressed in cycle k arrives in cycle k+1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= 2'b00;
                end else if (busy_reg && (idx_reg == IDX_W'(gi + 1))) begin
                    slot_reg <= b_data;
                end
            end

            assign tile[2*gi +: 2] = slot_reg;
        end
    endgenerate

endmodule

// File: rtl/pe_array_ctrl.sv
// Tiles gene B over the systolic PE array, streams all of gene A per tile and
// keeps the best array max score across tiles.
module pe_array_ctrl
    import gene_pkg::*;
#(
    parameter int PE_NUM  = DEF_PE_NUM,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int DRAIN   = DEF_DRAIN
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_go,
    input  logic [LEN_W-1:0]    i_len_a,
    input  logic [LEN_W-1:0]    i_len_b,
    output logic [LEN_W-1:0]    o_a_addr,
    input  logic [1:0]          i_a_data,
    output logic [LEN_W-1:0]    o_b_addr,
    input  logic [1:0]          i_b_data,
    output logic [2*PE_NUM-1:0] o_pe_B,
    output logic [1:0]          o_pe_A,
    output logic                o_pe_start,
    output logic                o_pe_clear,
    input  logic [SCORE_W-1:0]  i_pe_max,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [SCORE_W-1:0]  o_score,
    output logic [LEN_W-1:0]    o_tile
);

    ctrl_state_e        state_reg;
    logic [LEN_W-1:0]   cnt_reg;
    logic [LEN_W-1:0]   len_a_reg;
    logic [LEN_W-1:0]   last_tile_reg;
    logic [LEN_W-1:0]   a_addr_reg;
    logic [LEN_W-1:0]   tile_reg;
    logic [SCORE_W-1:0] score_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;
    logic               clear_reg;

    logic               len_ok;
    logic               last_tile;
    logic               ld_start;
    logic               ld_done;
    logic [LEN_W-1:0]   ld_base;

    assign len_ok    = (i_len_a != '0) && (i_len_b != '0) &&
                       ((i_len_b % LEN_W'(PE_NUM)) == '0);
    assign last_tile = (tile_reg == last_tile_reg);

    // The loader is kicked on the edge that enters LOAD_B, so its cycle 0
    // coincides with the first LOAD_B cycle.
    assign ld_start = ((state_reg == ST_IDLE) && i_go && len_ok) ||
                      ((state_reg == ST_CAPTURE) && !last_tile);
    assign ld_base  = (state_reg == ST_CAPTURE) ?
                      LEN_W'((32'(tile_reg) + 1) * PE_NUM) : '0;

    b_tile_loader #(
        .PE_NUM (PE_NUM),
        .LEN_W  (LEN_W)
    ) u_b_tile_loader (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .start     (ld_start),
        .tile_base (ld_base),
        .b_addr    (o_b_addr),
        .b_data    (i_b_data),
        .done      (ld_done),
        .tile      (o_pe_B)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            len_a_reg     <= '0;
            last_tile_reg <= '0;
            a_addr_reg    <= '0;
            tile_reg      <= '0;
            score_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            clear_reg     <= 1'b0;
        end else begin
            cnt_reg   <= cnt_reg + 1'b1;
            done_reg  <= 1'b0;
            clear_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    if (i_go) begin
                        score_reg     <= '0;
                        tile_reg      <= '0;
                        len_a_reg     <= i_len_a;
                        last_tile_reg <= (i_len_b / LEN_W'(PE_NUM)) - 1'b1;
                        if (len_ok) begin
                            state_reg  <= ST_LOAD_B;
                            busy_reg   <= 1'b1;
                            a_addr_reg <= '0;
                        end else begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (ld_done) begin
                        state_reg <= ST_CLEAR;
                        cnt_reg   <= '0;
                        clear_reg <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Base 0 was addressed during CLEAR; point at base 1 now.
                    state_reg  <= ST_STREAM;
                    cnt_reg    <= '0;
                    a_addr_reg <= (len_a_reg > LEN_W'(1)) ? LEN_W'(1) : '0;
                end
                ST_STREAM: begin
                    if (a_addr_reg != len_a_reg - 1'b1) begin
                        a_addr_reg <= a_addr_reg + 1'b1;
                    end
                    if (cnt_reg == len_a_reg - 1'b1) begin
                        state_reg <= ST_DRAIN;
                        cnt_reg   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_reg == LEN_W'(DRAIN - 1)) begin
                        state_reg <= ST_CAPTURE;
                        cnt_reg   <= '0;
                    end
                end
                ST_CAPTURE: begin
                    cnt_reg  <= '0;
                    tile_reg <= tile_reg + 1'b1;
                    if (i_pe_max > score_reg) begin
                        score_reg <= i_pe_max;
                    end
                    if (last_tile) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg  <= ST_LOAD_B;
                        a_addr_reg <= '0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    err_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_a_addr   = a_addr_reg;
    assign o_pe_start = (state_reg == ST_STREAM);
    assign o_pe_A     = o_pe_start ? i_a_data : 2'(BASE_A);
    assign o_pe_clear = clear_reg;
    assign o_busy     = busy_reg;
    assign o_done     = done_reg;
    assign o_err      = err_reg;
    assign o_score    = score_reg;
    assign o_tile     = tile_reg;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl: gene memories, a drain-delayed array max
// model, a vector table of runs and hand-written reset/abort sequences.
module tb_pe_array_ctrl;

    localparam int PE_NUM  = 64;
    localparam int LEN_W   = 10;
    localparam int SCORE_W = 10;
    localparam int DRAIN   = 66;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                go = 1'b0;
    logic [LEN_W-1:0]    len_a = '0;
    logic [LEN_W-1:0]    len_b = '0;
    logic [LEN_W-1:0]    a_addr, b_addr;
    logic [1:0]          a_data = '0, b_data = '0;
    logic [2*PE_NUM-1:0] pe_B;
    logic [1:0]          pe_A;
    logic                pe_start, pe_clear;
    logic [SCORE_W-1:0]  pe_max = '0;
    logic                busy, done, err;
    logic [SCORE_W-1:0]  score;
    logic [LEN_W-1:0]    tile;

    always #5 clk = ~clk;

    pe_array_ctrl #(
        .PE_NUM (PE_NUM), .LEN_W (LEN_W), .SCORE_W (SCORE_W), .DRAIN (DRAIN)
    ) dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_go (go),
        .i_len_a (len_a), .i_len_b (len_b),
        .o_a_addr (a_addr), .i_a_data (a_data),
        .o_b_addr (b_addr), .i_b_data (b_data),
        .o_pe_B (pe_B), .o_pe_A (pe_A), .o_pe_start (pe_start), .o_pe_clear (pe_clear),
        .i_pe_max (pe_max),
        .o_busy (busy), .o_done (done), .o_err (err), .o_score (score), .o_tile (tile)
    );

    logic [1:0] mem_a [1024];
    logic [1:0] mem_b [1024];

    always @(posedge clk) begin
        a_data <= mem_a[a_addr];
        b_data <= mem_b[b_addr];
    end

    typedef struct {
        int len_a;
        int len_b;
        int mx0;
        int mx1;
        int mx2;
        bit exp_err;
        int exp_score;
        int exp_cycles;
        bit go_in_drain;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_fail   = 0;

    // per-run observation state
    int cyc, done_cyc, done_err, done_score;
    int start_cnt, clear_cnt, a_idx, since;
    int pa_err, pb_err, aa_err, ba_err, busy_err;
    int cur_len_a, cur_mx0, cur_mx1, cur_mx2, per, ntile;
    bit cur_legal;
    int hits [1024];
    int tiles_seen [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        done_cyc = -1; done_err = 0; done_score = 0;
        start_cnt = 0; clear_cnt = 0; a_idx = 0; since = -1;
        pa_err = 0; pb_err = 0; aa_err = 0; ba_err = 0; busy_err = 0;
        tiles_seen.delete();
        for (int i = 0; i < 1024; i++) hits[i] = 0;
    endtask

    // Advance one clock and observe the new cycle's outputs.
    task automatic tick();
        int off;
        int exp_addr;
        logic [127:0] expb;
        @(posedge clk);
        #1;
        cyc++;
        if (done && done_cyc < 0) begin
            done_cyc   = cyc;
            done_err   = int'(err);
            done_score = int'(score);
        end
        if (cur_legal) begin
            if (cyc >= 1 && done_cyc < 0 && !busy) busy_err++;
            if (done && busy) busy_err++;
            off = cyc - 1;
            if (off >= 0 && (off / per) < ntile && (off % per) < PE_NUM) begin
                exp_addr = (off / per) * PE_NUM + (off % per);
                if (int'(b_addr) != exp_addr) ba_err++;
                hits[b_addr]++;
            end
        end
        if (pe_clear) begin
            clear_cnt++;
            tiles_seen.push_back(int'(tile));
            if (a_addr != '0) aa_err++;
            a_idx  = 0;
            since  = -1;
            pe_max = '0;
        end else if (pe_start) begin
            start_cnt++;
            if (pe_A !== mem_a[a_idx]) pa_err++;
            exp_addr = (a_idx + 1 < cur_len_a) ? a_idx + 1 : cur_len_a - 1;
            if (int'(a_addr) != exp_addr) aa_err++;
            for (int k = 0; k < PE_NUM; k++) expb[2*k +: 2] = mem_b[int'(tile) * PE_NUM + k];
            if (pe_B !== expb) pb_err++;
            a_idx++;
            since = 0;
        end else if (since >= 0) begin
            since++;
        end
        if (since == DRAIN) begin
            case (int'(tile))
                0:       pe_max = SCORE_W'(cur_mx0);
                1:       pe_max = SCORE_W'(cur_mx1);
                default: pe_max = SCORE_W'(cur_mx2);
            endcase
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int inj;
        int cov_err;
        v = vecs[idx];
        clear_stats();
        cur_legal = !v.exp_err;
        cur_len_a = v.len_a;
        cur_mx0 = v.mx0; cur_mx1 = v.mx1; cur_mx2 = v.mx2;
        per   = PE_NUM + 1 + 1 + v.len_a + DRAIN + 1;
        ntile = v.len_b / PE_NUM;
        inj   = v.go_in_drain ? (PE_NUM + 3 + v.len_a + 10) : -10;
        @(posedge clk);
        #1;
        cyc   = 0;
        len_a = LEN_W'(v.len_a);
        len_b = LEN_W'(v.len_b);
        go    = 1'b1;
        while (done_cyc < 0 && cyc < 2000) begin
            tick();
            if (cyc == 1) go = 1'b0;
            if (cyc == inj) begin
                go = 1'b1; len_a = LEN_W'(7); len_b = LEN_W'(100);
            end
            if (cyc == inj + 1) begin
                go = 1'b0; len_a = LEN_W'(v.len_a); len_b = LEN_W'(v.len_b);
            end
        end
        $display("vec %0d: len_a=%0d len_b=%0d done_cyc=%0d score=%0d err=%0d starts=%0d clears=%0d",
                 idx, v.len_a, v.len_b, done_cyc, done_score, done_err, start_cnt, clear_cnt);
        check($sformatf("latency[%0d]", idx), 128'(done_cyc), 128'(v.exp_cycles));
        check($sformatf("err[%0d]", idx), 128'(done_err), 128'(v.exp_err));
        check($sformatf("score[%0d]", idx), 128'(done_score), 128'(v.exp_score));
        if (v.exp_err) begin
            check($sformatf("starts[%0d]", idx), 128'(start_cnt), 128'(0));
            check($sformatf("no_rd[%0d]", idx), {a_addr, b_addr}, 128'(0));
            go = 1'b0;
        end else begin
            check($sformatf("starts[%0d]", idx), 128'(start_cnt), 128'(ntile * v.len_a));
            check($sformatf("clears[%0d]", idx), 128'(clear_cnt), 128'(ntile));
            for (int i = 0; i < tiles_seen.size(); i++)
                check($sformatf("tile_seq[%0d]", idx), 128'(tiles_seen[i]), 128'(i));
            cov_err = 0;
            for (int i = 0; i < v.len_b; i++) if (hits[i] != 1) cov_err++;
            check($sformatf("b_addr_seq[%0d]", idx), 128'(ba_err), 128'(0));
            check($sformatf("b_addr_cov[%0d]", idx), 128'(cov_err), 128'(0));
            check($sformatf("pe_A[%0d]", idx), 128'(pa_err), 128'(0));
            check($sformatf("pe_B[%0d]", idx), 128'(pb_err), 128'(0));
            check($sformatf("a_addr[%0d]", idx), 128'(aa_err), 128'(0));
            check($sformatf("busy[%0d]", idx), 128'(busy_err), 128'(0));
            // i_go presented during the DONE cycle must not start a run.
            go = 1'b1;
            cur_legal = 1'b0;
            tick();
            go = 1'b0;
            check($sformatf("go_in_done[%0d]", idx), 128'(busy), 128'(0));
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 2'($urandom_range(0, 3));
            mem_b[i] = 2'($urandom_range(0, 3));
        end
        //         len_a len_b mx0  mx1   mx2 err score cycles drain_go
        vecs[0] = '{10,  100,  0,   0,    0,   1,  0,    1,     0};
        vecs[1] = '{0,   64,   0,   0,    0,   1,  0,    1,     0};
        vecs[2] = '{20,  0,    0,   0,    0,   1,  0,    1,     0};
        vecs[3] = '{64,  64,   128, 0,    0,   0,  128,  198,   0};
        vecs[4] = '{100, 192,  20,  57,   33,  0,  57,   700,   0};
        vecs[5] = '{1,   64,   5,   0,    0,   0,  5,    135,   0};
        vecs[6] = '{5,   128,  9,   3,    0,   0,  9,    277,   1};
        vecs[7] = '{3,   192,  300, 1000, 700, 0,  1000, 409,   0};

        cur_legal = 1'b0; cur_len_a = 1; per = 1; ntile = 0;
        cur_mx0 = 0; cur_mx1 = 0; cur_mx2 = 0;
        clear_stats();
        cyc = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy",  128'(busy),  128'(0));
        check("rst_done",  128'(done),  128'(0));
        check("rst_err",   128'(err),   128'(0));
        check("rst_score", 128'(score), 128'(0));
        check("rst_tile",  128'(tile),  128'(0));
        check("rst_pe_B",  pe_B,        128'(0));
        check("rst_ctl",   {a_addr, b_addr, pe_A, pe_start, pe_clear}, 128'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(i);

        // Abort during the second tile's STREAM: score from tile 0 must be lost.
        clear_stats();
        cur_legal = 1'b0; cur_len_a = 64; cur_mx0 = 40; cur_mx1 = 90; cur_mx2 = 0;
        @(posedge clk);
        #1;
        cyc = 0; len_a = LEN_W'(64); len_b = LEN_W'(128); go = 1'b1;
        tick();
        go = 1'b0;
        while (!(clear_cnt == 2 && start_cnt >= 69) && cyc < 1000) tick();
        check("abort_pre_score", 128'(score), 128'(40));
        rst_n = 1'b0;
        tick();
        $display("abort: reset at cycle %0d busy=%0d score=%0d tile=%0d", cyc, busy, score, tile);
        check("abort_busy",  128'(busy),  128'(0));
        check("abort_score", 128'(score), 128'(0));
        check("abort_tile",  128'(tile),  128'(0));
        check("abort_pe_B",  pe_B,        128'(0));
        check("abort_start", 128'(pe_start), 128'(0));
        rst_n = 1'b1;
        done_cyc = -1;
        repeat (300) tick();
        check("abort_no_done", 128'(done_cyc), 128'(-1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
